ahb_cmd_manager: RTL and testbench



---
 rtl/ahb_cmd_manager.sv | 149 ++++++++++++++
 tb/tb_ahb_cmd_manager.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_manager.sv
// AHB-Lite manager: queues single-transfer commands, runs them as pipelined NONSEQ
// transfers and returns one in-order response per command through a response FIFO.
module ahb_cmd_manager #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int FifoDepth    = 4
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [AddressWidth-1:0] cmd_addr,
    input  logic [2:0]              cmd_size,
    input  logic [DataWidth-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic [AddressWidth-1:0] HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [1:0]              HTRANS,
    output logic [DataWidth-1:0]    HWDATA,
    input  logic                    HREADY,
    input  logic [DataWidth-1:0]    HRDATA,
    input  logic                    HRESP
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(FifoDepth);

    typedef enum logic {ADDR_IDLE, ADDR_BUSY} addr_stage_t;
    typedef enum logic [1:0] {DATA_NONE, DATA_XFER, DATA_ERR} data_stage_t;

    addr_stage_t addr_stage;
    data_stage_t data_stage;
    logic        data_write;

    logic [AddressWidth-1:0] cmd_addr_mem  [FifoDepth];
    logic [DataWidth-1:0]    cmd_wdata_mem [FifoDepth];
    logic [2:0]              cmd_size_mem  [FifoDepth];
    logic                    cmd_write_mem [FifoDepth];
    logic [PtrW-1:0]         cmd_rd, cmd_wr;
    logic [CntW-1:0]         cmd_count;

    logic [DataWidth-1:0]    rsp_data_mem [FifoDepth];
    logic                    rsp_err_mem  [FifoDepth];
    logic [PtrW-1:0]         rsp_rd, rsp_wr;
    logic [CntW-1:0]         rsp_count;

    logic                 addr_busy, data_busy, err_first, addr_adv;
    logic                 cmd_push, cmd_pop, cmd_avail, rsp_push, rsp_pop, launch;
    logic                 rsp_push_err;
    logic [DataWidth-1:0] rsp_push_data;
    logic [PtrW-1:0]      launch_ptr;
    logic [CntW:0]        credits_used;

    assign addr_busy = (addr_stage == ADDR_BUSY);
    assign data_busy = (data_stage != DATA_NONE);
    // First cycle of a two-cycle ERROR response: cancel whatever sits in the address stage.
    assign err_first = (data_stage == DATA_XFER) && HRESP && !HREADY;
    assign addr_adv  = !addr_busy || HREADY;
    assign cmd_pop   = addr_busy && HREADY;

    // The address stage always holds the FIFO head, so a new launch reads one entry past it.
    assign cmd_avail    = cmd_pop ? (cmd_count > CntW'(1)) : (cmd_count != '0);
    assign launch_ptr   = cmd_pop ? cmd_rd + PtrW'(1) : cmd_rd;
    assign credits_used = {1'b0, rsp_count} + (CntW+1)'(addr_busy) + (CntW+1)'(data_busy);
    assign launch       = addr_adv && !err_first && cmd_avail &&
                          (credits_used < (CntW+1)'(FifoDepth));

    assign rsp_push      = HREADY && data_busy;
    assign rsp_push_err  = (data_stage == DATA_ERR) || HRESP;
    assign rsp_push_data = (!rsp_push_err && !data_write) ? HRDATA : '0;

    assign cmd_ready = !HRESET && ((cmd_count != Full) || cmd_pop);
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? rsp_data_mem[rsp_rd] : '0;
    assign rsp_error = rsp_valid ? rsp_err_mem[rsp_rd] : 1'b0;
    assign HTRANS    = (addr_busy && !err_first) ? 2'b10 : 2'b00;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_stage <= ADDR_IDLE;
            data_stage <= DATA_NONE;
            data_write <= 1'b0;
            cmd_rd     <= '0;
            cmd_wr     <= '0;
            cmd_count  <= '0;
            rsp_rd     <= '0;
            rsp_wr     <= '0;
            rsp_count  <= '0;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= '0;
            HWDATA     <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + PtrW'(1);
            if (cmd_pop)  cmd_rd <= cmd_rd + PtrW'(1);
            cmd_count <= cmd_count + CntW'(cmd_push) - CntW'(cmd_pop);

            if (rsp_push) rsp_wr <= rsp_wr + PtrW'(1);
            if (rsp_pop)  rsp_rd <= rsp_rd + PtrW'(1);
            rsp_count <= rsp_count + CntW'(rsp_push) - CntW'(rsp_pop);

            // Address stage -> data stage boundary
            if (err_first) begin
                addr_stage <= ADDR_IDLE;
                data_stage <= DATA_ERR;
            end else begin
                if (addr_adv) addr_stage <= launch ? ADDR_BUSY : ADDR_IDLE;
                if (HREADY) begin
                    if (addr_busy) begin
                        data_stage <= DATA_XFER;
                        data_write <= HWRITE;
                        HWDATA     <= cmd_wdata_mem[cmd_rd];
                    end else begin
                        data_stage <= DATA_NONE;
                    end
                end
            end

            if (launch) begin
                HADDR  <= cmd_addr_mem[launch_ptr];
                HWRITE <= cmd_write_mem[launch_ptr];
                HSIZE  <= cmd_size_mem[launch_ptr];
            end
        end
    end

    // FIFO storage carries data only, so it needs no reset.
    always_ff @(posedge HCLK) begin
        if (cmd_push) begin
            cmd_addr_mem[cmd_wr]  <= cmd_addr;
            cmd_wdata_mem[cmd_wr] <= cmd_wdata;
            cmd_size_mem[cmd_wr]  <= cmd_size;
            cmd_write_mem[cmd_wr] <= cmd_write;
        end
        if (rsp_push) begin
            rsp_data_mem[rsp_wr] <= rsp_push_data;
            rsp_err_mem[rsp_wr]  <= rsp_push_err;
        end
    end

endmodule

// File: tb/tb_ahb_cmd_manager.sv
// Scoreboard bench for ahb_cmd_manager with a behavioural AHB subordinate that
// inserts planned wait states and ERROR responses per transfer.
module tb_ahb_cmd_manager;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] HADDR;
    logic          HWRITE, HREADY, HRESP;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HWDATA, HRDATA;

    always #5 HCLK = ~HCLK;

    ahb_cmd_manager #(.AddressWidth(AW), .DataWidth(DW), .FifoDepth(DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t exp_item;

    logic [31:0] log_addr  [256];
    logic [31:0] log_wdata [256];
    logic        log_write [256];
    logic [2:0]  log_size  [256];
    bit          err_plan  [256];
    int          waits_plan[256];
    int          acc_cnt  = 0;
    int          rsp_mode = 0;
    int          popped   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response consumer
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge HCLK);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                2:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the expected queue whenever the DUT hands over a response
    initial begin
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                exp_q.delete();
                popped = 0;
            end else if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got rdata=%0h error=%0b with none expected",
                             rsp_rdata, rsp_error);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_item.rdata));
                    check("rsp_error", 64'(rsp_error), 64'(exp_item.err));
                end
                popped++;
            end
        end
    end

    // Subordinate model: the k-th data phase since reset belongs to the k-th accepted command
    bit          dp_active = 0, dp_err = 0, dp_write = 0, err_c1 = 0;
    int          dp_idx = 0, next_dp = 0, dp_waits = 0, dp_errph = 0;
    logic [31:0] dp_addr = 0;
    bit          l_ready = 1, l_nonseq = 0, l_write = 0, p_ready = 1, p_nonseq = 0;
    logic [31:0] l_addr = 0, p_addr = 0;
    logic [2:0]  l_size = 0;
    int          run = 0, run4_cnt = 0;

    initial begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(posedge HCLK);
            if (HRESET) begin
                dp_active = 0;
                next_dp   = 0;
                l_ready   = 1;
                l_nonseq  = 0;
                run       = 0;
            end else if (l_ready) begin
                dp_active = l_nonseq;
                if (l_nonseq) begin
                    dp_idx   = next_dp;
                    next_dp++;
                    dp_write = l_write;
                    dp_addr  = l_addr;
                    dp_waits = waits_plan[dp_idx];
                    dp_err   = err_plan[dp_idx];
                    dp_errph = 0;
                    check("credit_limit", 64'((next_dp - popped) <= DEPTH), 64'd1);
                    if (dp_idx >= acc_cnt) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL phantom_xfer: got transfer %0d with %0d commands accepted",
                                 dp_idx, acc_cnt);
                    end else begin
                        check("haddr", 64'(l_addr), 64'(log_addr[dp_idx]));
                        check("hwrite", 64'(l_write), 64'(log_write[dp_idx]));
                        check("hsize", 64'(l_size), 64'(log_size[dp_idx]));
                    end
                end
            end
            #1;
            if (!dp_active) begin
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
            end else if (dp_waits > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; dp_waits--;
            end else if (dp_err) begin
                if (dp_errph == 0) begin
                    HREADY = 1'b0; HRESP = 1'b1; dp_errph = 1;
                end else begin
                    HREADY = 1'b1; HRESP = 1'b1;
                end
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
                HRDATA = dp_write ? $urandom : dp_addr + 32'h100;
            end
            #1;
            p_ready  = l_ready;
            p_nonseq = l_nonseq;
            p_addr   = l_addr;
            l_ready  = HREADY;
            l_nonseq = (HTRANS == 2'b10);
            l_addr   = HADDR;
            l_write  = HWRITE;
            l_size   = HSIZE;
            if (!HRESET) begin
                err_c1 = dp_active && dp_err && HRESP && !HREADY;
                if (err_c1) begin
                    check("err_cycle_htrans", 64'(HTRANS), 64'd0);
                end else if (!p_ready && p_nonseq) begin
                    check("hold_htrans", 64'(HTRANS), 64'd2);
                    check("hold_haddr", 64'(HADDR), 64'(p_addr));
                end
                if (dp_active && HREADY && dp_write && !dp_err)
                    check("hwdata", 64'(HWDATA), 64'(log_wdata[dp_idx]));
                run = l_nonseq ? run + 1 : 0;
                if (run == 4) run4_cnt++;
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the command is taken.
    task automatic send(input bit w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, input bit e, input int wt);
        int t;
        rsp_t r;
        t = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
        @(negedge HCLK);
        while (!cmd_ready && t < 1000) begin
            @(negedge HCLK);
            t++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 1000 cycles");
        end else begin
            log_addr[acc_cnt]   = a;
            log_wdata[acc_cnt]  = d;
            log_write[acc_cnt]  = w;
            log_size[acc_cnt]   = s;
            err_plan[acc_cnt]   = e;
            waits_plan[acc_cnt] = wt;
            r.err   = e;
            r.rdata = (e || w) ? 32'h0 : a + 32'h100;
            exp_q.push_back(r);
            acc_cnt++;
        end
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge HCLK);
            t++;
        end
        repeat (2) @(negedge HCLK);
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_htrans"}, 64'(HTRANS), 64'd0);
        check({tag, "_haddr"}, 64'(HADDR), 64'd0);
        check({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
        check({tag, "_hsize"}, 64'(HSIZE), 64'd0);
        check({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        logic [2:0]  s;
        logic [31:0] a;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_reset_vals("init");
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
        @(posedge HCLK);
        #1;

        send(1, 32'h1000_0000, 3'd2, 32'hDEAD_BEEF, 0, 0);
        drain("drain_single_write");

        base = run4_cnt;
        for (int i = 0; i < 4; i++) send(0, 32'(i * 4), 3'd2, 32'h0, 0, 0);
        drain("drain_b2b_reads");
        check("b2b_nonseq_run", 64'(run4_cnt > base), 64'd1);

        send(1, 32'h0000_2000, 3'd2, 32'h1111_1111, 0, 0);
        send(1, 32'h0000_2004, 3'd2, 32'h2222_2222, 0, 2);
        send(1, 32'h0000_2008, 3'd2, 32'h3333_3333, 0, 0);
        drain("drain_wait_writes");

        send(0, 32'h0000_3000, 3'd2, 32'h0, 1, 0);
        send(0, 32'h0000_3004, 3'd2, 32'h0, 0, 0);
        drain("drain_error_reads");

        rsp_mode = 2;
        base = next_dp;
        for (int i = 0; i < 6; i++) send(0, 32'h0000_4000 + 32'(i * 4), 3'd2, 32'h0, 0, 0);
        repeat (20) @(posedge HCLK);
        @(negedge HCLK);
        check("stall_issue_count", 64'(next_dp - base), 64'd4);
        check("stall_htrans_idle", 64'(HTRANS), 64'd0);
        @(posedge HCLK);
        #1 rsp_mode = 0;
        drain("drain_stalled_reads");

        send(0, 32'h0000_5000, 3'd2, 32'h0, 0, 4);
        send(0, 32'h0000_5004, 3'd2, 32'h0, 0, 0);
        send(0, 32'h0000_5008, 3'd2, 32'h0, 0, 0);
        t = 0;
        while (!dp_active && t < 50) begin
            @(negedge HCLK);
            t++;
        end
        check("reset_test_in_data_phase", 64'(dp_active), 64'd1);
        @(posedge HCLK);
        #1 HRESET = 1'b1;
        acc_cnt = 0;
        @(negedge HCLK);
        check_reset_vals("mid");
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        check("cmd_ready_after_mid_reset", 64'(cmd_ready), 64'd1);
        check("rsp_valid_after_mid_reset", 64'(rsp_valid), 64'd0);
        repeat (10) @(posedge HCLK);
        @(negedge HCLK);
        check("no_rsp_after_reset", 64'(popped), 64'd0);
        @(posedge HCLK);
        #1;

        rsp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            s = 3'($urandom_range(0, 2));
            a = $urandom & ~((32'd1 << s) - 32'd1);
            send(1'($urandom_range(0, 1)), a, s, $urandom,
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge HCLK);
                    #1;
                end
            end
        end
        drain("drain_random");
        rsp_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
